// File: rtl/cmd_parser.sv
// -----------------------------------------------------------------------------
// cmd_parser
//   Parses the byte stream that arrives from an FX2 OUT endpoint into register
//   accesses, and returns read data as a byte-wise reply to an FX2 IN endpoint.
//
//   Frame format: opcode, address, then four data bytes LSB first (write only).
//     0x01 = register write, 0x02 = register read. Any other opcode is answered
//     with the single reply byte 0xEE.
//
//   Optional feature (macro CMD_TIMEOUT_EN): a partial frame that is left idle
//   in ADDR or DATA for TIMEOUT_CYCLES consecutive cycles is abandoned.
//   Without the macro the parser waits for the rest of the frame indefinitely.
//
//   Ports
//     fx2_clk     in   clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     cmd_wr      in   one-cycle strobe, cmd valid
//     cmd[7:0]    in   command byte
//     reg_addr    out  register address for reg_wr / reg_rd
//     reg_wdata   out  register write data
//     reg_wr      out  one-cycle register write strobe
//     reg_rd      out  one-cycle register read strobe
//     reg_rdata   in   read data, valid the cycle after reg_rd
//     reply_rdy   out  reply byte valid
//     reply[7:0]  out  reply byte
//     reply_ack   in   one-cycle strobe, current reply byte consumed
//     reply_end   out  high with the final byte of a reply
//     cmd_overrun out  sticky flag, a command byte was dropped
// -----------------------------------------------------------------------------
module cmd_parser #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        fx2_clk,
    input  logic        reset_n,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [31:0] reg_rdata,
    output logic        reply_rdy,
    output logic [7:0]  reply,
    input  logic        reply_ack,
    output logic        reply_end,
    output logic        cmd_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RDREQ = 3'd3,
        ST_RDCAP = 3'd4,
        ST_REPLY = 3'd5
    } state_e;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] REPLY_ERR = 8'hEE;

    state_e      state_q;
    logic        is_wr_q;      // frame in progress is a write
    logic [1:0]  byte_cnt_q;   // data byte index in DATA, reply byte index in REPLY
    logic [23:0] rbuf_q;       // upper reply bytes not yet presented
    logic [7:0]  reg_addr_q;
    logic [31:0] reg_wdata_q;
    logic        reg_wr_q;
    logic        reg_rd_q;
    logic        reply_rdy_q;
    logic [7:0]  reply_q;
    logic        reply_end_q;
    logic        overrun_q;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q; // idle cycles seen in ADDR/DATA since the last byte
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
`endif

    // Parser FSM: byte consumption, register strobes, reply sequencing, overrun flag.
    always_ff @(posedge fx2_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            byte_cnt_q  <= 2'd0;
            rbuf_q      <= 24'd0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 32'd0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reply_rdy_q <= 1'b0;
            reply_q     <= 8'd0;
            reply_end_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q    <= {TO_W{1'b0}};
`endif
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;

`ifdef CMD_TIMEOUT_EN
            if (cmd_wr) begin
                to_cnt_q <= {TO_W{1'b0}};
            end else begin
                to_cnt_q <= to_cnt_q;
            end
`endif

            case (state_q)
                ST_IDLE: begin
                    if (cmd_wr) begin
                        if ((cmd == OP_WRITE) || (cmd == OP_READ)) begin
                            is_wr_q <= (cmd == OP_WRITE);
                            state_q <= ST_ADDR;
                        end else begin
                            reply_q     <= REPLY_ERR;
                            reply_end_q <= 1'b1;
                            reply_rdy_q <= 1'b1;
                            byte_cnt_q  <= 2'd0;
                            state_q     <= ST_REPLY;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_ADDR: begin
                    if (cmd_wr) begin
                        reg_addr_q <= cmd;
                        byte_cnt_q <= 2'd0;
                        if (is_wr_q) begin
                            state_q <= ST_DATA;
                        end else begin
                            // reg_rd is high during RDREQ, alongside the new address.
                            reg_rd_q <= 1'b1;
                            state_q  <= ST_RDREQ;
                        end
                    end else begin
`ifdef CMD_TIMEOUT_EN
                        if (to_cnt_q == TO_LAST) begin
                            to_cnt_q <= {TO_W{1'b0}};
                            state_q  <= ST_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
`else
                        state_q <= ST_ADDR;
`endif
                    end
                end

                ST_DATA: begin
                    if (cmd_wr) begin
                        reg_wdata_q[8*byte_cnt_q +: 8] <= cmd;
                        if (byte_cnt_q == 2'd3) begin
                            reg_wr_q   <= 1'b1;
                            byte_cnt_q <= 2'd0;
                            state_q    <= ST_IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end else begin
`ifdef CMD_TIMEOUT_EN
                        if (to_cnt_q == TO_LAST) begin
                            to_cnt_q   <= {TO_W{1'b0}};
                            byte_cnt_q <= 2'd0;
                            state_q    <= ST_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
`else
                        state_q <= ST_DATA;
`endif
                    end
                end

                ST_RDREQ: begin
                    // reg_rdata becomes valid in the following cycle (RDCAP).
                    state_q <= ST_RDCAP;
                end

                ST_RDCAP: begin
                    reply_q     <= reg_rdata[7:0];
                    rbuf_q      <= reg_rdata[31:8];
                    reply_end_q <= 1'b0;
                    reply_rdy_q <= 1'b1;
                    byte_cnt_q  <= 2'd0;
                    state_q     <= ST_REPLY;
                end

                ST_REPLY: begin
                    if (reply_ack && reply_rdy_q) begin
                        if (reply_end_q) begin
                            reply_rdy_q <= 1'b0;
                            reply_end_q <= 1'b0;
                            byte_cnt_q  <= 2'd0;
                            state_q     <= ST_IDLE;
                        end else begin
                            reply_q     <= rbuf_q[7:0];
                            rbuf_q      <= {8'd0, rbuf_q[23:8]};
                            byte_cnt_q  <= byte_cnt_q + 2'd1;
                            reply_end_q <= (byte_cnt_q == 2'd2);
                        end
                    end else begin
                        state_q <= ST_REPLY;
                    end
                end

                default: begin
                    reply_rdy_q <= 1'b0;
                    reply_end_q <= 1'b0;
                    byte_cnt_q  <= 2'd0;
                    state_q     <= ST_IDLE;
                end
            endcase

            // Bytes arriving while a read is being served are dropped.
            if (cmd_wr && ((state_q == ST_RDREQ) || (state_q == ST_RDCAP) ||
                           (state_q == ST_REPLY))) begin
                overrun_q <= 1'b1;
            end else begin
                overrun_q <= overrun_q;
            end
        end
    end

    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_wr      = reg_wr_q;
    assign reg_rd      = reg_rd_q;
    assign reply_rdy   = reply_rdy_q;
    assign reply       = reply_q;
    assign reply_end   = reply_end_q;
    assign cmd_overrun = overrun_q;

endmodule

// File: tb/tb_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_cmd_parser
//   Scoreboard bench for cmd_parser. Stimulus pushes expected register writes,
//   reads and reply bytes into queues; a monitor pops and compares whenever the
//   DUT strobes reg_wr / reg_rd or a reply byte is handshaken.
// -----------------------------------------------------------------------------
module tb_cmd_parser;

`ifdef CMD_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 65535;
`endif

    logic        fx2_clk = 1'b0;
    logic        reset_n;
    logic        cmd_wr;
    logic [7:0]  cmd;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reply_rdy;
    logic [7:0]  reply;
    logic        reply_ack;
    logic        reply_end;
    logic        cmd_overrun;

    always #5 fx2_clk = ~fx2_clk;

    cmd_parser #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .fx2_clk    (fx2_clk),
        .reset_n    (reset_n),
        .cmd_wr     (cmd_wr),
        .cmd        (cmd),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .reply_rdy  (reply_rdy),
        .reply      (reply),
        .reply_ack  (reply_ack),
        .reply_end  (reply_end),
        .cmd_overrun(cmd_overrun)
    );

    logic [39:0] exp_wr[$];   // {addr, data}
    logic [7:0]  exp_rd[$];   // addr
    logic [8:0]  exp_rep[$];  // {end, byte}

    int n_tests = 0;
    int n_fail  = 0;

    int ack_delay = 0;
    bit ack_en    = 1'b1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected", name);
    endtask

    // Called at a negedge; holds cmd_wr for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        cmd_wr = 1'b1;
        cmd    = b;
        @(negedge fx2_clk);
        cmd_wr = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
        send_byte(8'h01);
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic send_read(input logic [7:0] a, input logic [31:0] d);
        reg_rdata = d;
        exp_rd.push_back(a);
        for (int i = 0; i < 4; i++) exp_rep.push_back({(i == 3), d[8*i +: 8]});
        send_byte(8'h02);
        send_byte(a);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (((exp_wr.size() + exp_rd.size() + exp_rep.size()) != 0 || reply_rdy) && k < 400) begin
            @(negedge fx2_clk);
            k++;
        end
        check(name, {39'd0, (k < 400)}, 40'd1);
        repeat (4) @(negedge fx2_clk);
    endtask

    // Reply consumer: drives reply_ack shortly after the clock edge.
    initial begin
        int wcnt;
        wcnt = 0;
        reply_ack = 1'b0;
        forever begin
            @(posedge fx2_clk);
            #2;
            if (reply_ack) begin
                reply_ack = 1'b0;
            end else if (reply_rdy && ack_en) begin
                if (wcnt >= ack_delay) begin
                    reply_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    logic       hold_q;
    logic [8:0] held_q;

    // Monitor: compares every strobe and reply handshake against the scoreboard.
    always @(negedge fx2_clk) begin
        if (!reset_n) begin
            hold_q <= 1'b0;
        end else begin
            if (reg_wr || reg_rd) check("wr_rd_exclusive", {39'd0, reg_wr & reg_rd}, 40'd0);
            if (reg_wr) begin
                if (exp_wr.size() == 0) unexpected("reg_wr");
                else begin
                    logic [39:0] e;
                    e = exp_wr.pop_front();
                    check("reg_wr_addr", {32'd0, reg_addr}, {32'd0, e[39:32]});
                    check("reg_wr_data", {8'd0, reg_wdata}, {8'd0, e[31:0]});
                end
            end
            if (reg_rd) begin
                if (exp_rd.size() == 0) unexpected("reg_rd");
                else begin
                    logic [7:0] e;
                    e = exp_rd.pop_front();
                    check("reg_rd_addr", {32'd0, reg_addr}, {32'd0, e});
                end
            end
            if (hold_q && reply_rdy) check("reply_stable", {31'd0, reply_end, reply}, {31'd0, held_q});
            if (reply_rdy && reply_ack) begin
                if (exp_rep.size() == 0) unexpected("reply");
                else begin
                    logic [8:0] e;
                    e = exp_rep.pop_front();
                    check("reply_byte", {31'd0, reply_end, reply}, {31'd0, e});
                end
            end
            hold_q <= reply_rdy && !reply_ack;
            held_q <= {reply_end, reply};
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reg_addr"},  {32'd0, reg_addr}, 40'd0);
        check({tag, "_reg_wdata"}, {8'd0, reg_wdata}, 40'd0);
        check({tag, "_reg_wr"},    {39'd0, reg_wr}, 40'd0);
        check({tag, "_reg_rd"},    {39'd0, reg_rd}, 40'd0);
        check({tag, "_reply_rdy"}, {39'd0, reply_rdy}, 40'd0);
        check({tag, "_reply"},     {32'd0, reply}, 40'd0);
        check({tag, "_reply_end"}, {39'd0, reply_end}, 40'd0);
        check({tag, "_overrun"},   {39'd0, cmd_overrun}, 40'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_wr    = 1'b0;
        cmd       = 8'h00;
        reg_rdata = 32'h0;
        repeat (3) @(negedge fx2_clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge fx2_clk);

        // Basic write frame.
        send_write(8'h10, 32'h12345678);
        drain("drain_write");

        // Basic read frame, immediate acks.
        ack_delay = 0;
        send_read(8'h05, 32'hA1B2C3D4);
        drain("drain_read");

        // Unknown opcode, then a new frame after the error reply.
        ack_delay = 2;
        exp_rep.push_back({1'b1, 8'hEE});
        send_byte(8'h7F);
        drain("drain_err");
        send_write(8'h33, 32'hDEADBEEF);
        drain("drain_after_err");

        // Back-to-back write then read, no idle gap.
        ack_delay = 1;
        send_write(8'h40, 32'h01020304);
        send_read(8'h41, 32'h0055AA11);
        drain("drain_b2b");

        // Overrun while the reply is withheld.
        ack_en = 1'b0;
        send_read(8'h05, 32'hA1B2C3D4);
        repeat (20) @(negedge fx2_clk);
        check("pre_overrun_flag", {39'd0, cmd_overrun}, 40'd0);
        send_byte(8'h01);
        @(negedge fx2_clk);
        check("overrun_flag", {39'd0, cmd_overrun}, 40'd1);
        check("overrun_reply", {31'd0, reply_rdy, reply}, {31'd0, 1'b1, 8'hD4});
        ack_en = 1'b1;
        drain("drain_overrun");
        check("overrun_sticky", {39'd0, cmd_overrun}, 40'd1);

`ifdef CMD_TIMEOUT_EN
        // Abandoned write after exactly TB_TO idle cycles, then a clean read.
        send_byte(8'h01);
        send_byte(8'h10);
        repeat (TB_TO) @(negedge fx2_clk);
        send_read(8'h05, 32'h0BADF00D);
        drain("drain_timeout");
`else
        // Without a timeout the parser waits out a long gap mid-frame.
        exp_wr.push_back({8'h10, 32'hCAFE0123});
        send_byte(8'h01);
        send_byte(8'h10);
        repeat (40) @(negedge fx2_clk);
        send_byte(8'h23);
        send_byte(8'h01);
        send_byte(8'hFE);
        send_byte(8'hCA);
        drain("drain_no_timeout");
`endif

        // Reset after the third byte of a write frame.
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'hAA);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge fx2_clk);
        reset_n = 1'b1;
        repeat (12) @(negedge fx2_clk);
        send_write(8'h21, 32'h89ABCDEF);
        drain("drain_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535: idle cycles allowed between bytes of one frame (used only with CMD_TIMEOUT_EN).
REQ-002 fx2_clk  input  1  single clock; all logic rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_wr  input  1  one-cycle strobe; cmd byte valid.
REQ-005 cmd  input  8  command byte from FX2 OUT endpoint.
REQ-006 reg_addr  output  8  register address for reg_wr/reg_rd.
REQ-007 reg_wdata  output  32  register write data.
REQ-008 reg_wr  output  1  one-cycle register write strobe.
REQ-009 reg_rd  output  1  one-cycle register read strobe.
REQ-010 reg_rdata  input  32  read data, valid the cycle after reg_rd.
REQ-011 reply_rdy  output  1  reply byte valid.
REQ-012 reply  output  8  reply byte to FX2 IN endpoint.
REQ-013 reply_ack  input  1  one-cycle strobe; current reply byte consumed.
REQ-014 reply_end  output  1  high with the final byte of a reply; commits the packet.
REQ-015 cmd_overrun  output  1  sticky: a cmd byte was dropped.

Function
REQ-016 Frame: opcode, address, then 4 data bytes LSB first for write only; 0x01 = write, 0x02 = read.
REQ-017 States IDLE, ADDR, DATA, RDREQ, RDCAP, REPLY; one byte consumed per cmd_wr.
REQ-018 IDLE: cmd_wr with 0x01 or 0x02 -> ADDR; any other opcode -> REPLY with single byte 0xEE, reply_end high.
REQ-019 ADDR: cmd_wr latches reg_addr; write -> DATA (byte counter 0); read -> RDREQ.
REQ-020 DATA: cmd_wr latches byte k into reg_wdata[8k+7:8k]; on k=3, reg_wr pulses the next cycle, state returns to IDLE; write produces no reply.
REQ-021 RDREQ: reg_rd pulses for exactly one cycle -> RDCAP; RDCAP: reg_rdata captured into reply buffer -> REPLY.
REQ-022 REPLY (read): bytes 0..3 presented LSB first; reply_rdy high from the cycle after entry until the last byte is acked; reply_end high only with byte 3.
REQ-023 reply and reply_end stay stable while reply_rdy is high and reply_ack is low; reply_ack while reply_rdy low is ignored.
REQ-024 reply_ack on the last byte: reply_rdy and reply_end fall the next cycle; state -> IDLE; back-to-back frames allowed with no idle gap.
REQ-025 cmd_wr in RDREQ, RDCAP or REPLY: byte dropped, cmd_overrun set; frame in progress unaffected.
REQ-026 reg_wr and reg_rd never high in the same cycle; each at most one cycle per frame.
REQ-027 reg_addr and reg_wdata hold their last values between frames.

Reset
REQ-028 reset_n low, any state: state IDLE, reg_addr 0, reg_wdata 0, reg_wr 0, reg_rd 0, reply_rdy 0, reply 0, reply_end 0, cmd_overrun 0, counters 0, asynchronously.
REQ-029 Reset mid-frame or mid-reply discards the partial frame and pending reply; no strobe issued after release until a new complete frame.

Configuration
REQ-030 Macro CMD_TIMEOUT_EN defined: in ADDR or DATA, TIMEOUT_CYCLES consecutive cycles without cmd_wr return the parser to IDLE, no reg_wr, no reply; counter reloads on every cmd_wr.
REQ-031 Macro CMD_TIMEOUT_EN undefined: no timeout counter; parser waits in ADDR/DATA indefinitely.

Verification
REQ-032 Bytes 01 10 78 56 34 12 -> one reg_wr, reg_addr 0x10, reg_wdata 0x12345678, reply_rdy never high.
REQ-033 Bytes 02 05, reg_rdata 0xA1B2C3D4 -> one reg_rd, reply 0xD4,0xC3,0xB2,0xA1 each held until reply_ack, reply_end only with 0xA1.
REQ-034 Byte 0x7F -> single reply 0xEE with reply_end; next byte 01 parsed as a new opcode.
REQ-035 Read in REPLY with reply_ack withheld 20 cycles, then cmd_wr 0x01 -> byte dropped, cmd_overrun 1, reply bytes unchanged.
REQ-036 CMD_TIMEOUT_EN, TIMEOUT_CYCLES 16: bytes 01 10 then 16 idle cycles, then 02 05 -> no reg_wr, read of 0x05 completes normally.
REQ-037 reset_n low after third byte of a write frame -> all outputs at reset values immediately; after release, no reg_wr.
